// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   // Default mask used to move the memory's latched read address away after a write
   localparam logic [ADDR_W-1:0] INVAL_XOR_DEF = 32'h0000_0004;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      WR    = 2'd2,
      INVAL = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Transaction captured at grant time; requester fields are ignored afterwards
   typedef struct packed {
      owner_e              owner;
      logic                we;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [STRB_W-1:0]   wstrb;
   } txn_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker with optional fixed data priority.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,    // [0] fetch, [1] data
   input  owner_e     last_i,   // owner of the most recent grant
   input  logic       prio_i,   // 1: data wins every conflict
   output logic       valid_o,
   output owner_e     grant_o
);

   // On conflict favour data under priority, otherwise whoever was not served last
   always_comb begin
      valid_o = |req_i;
      grant_o = OWN_I;
      if (req_i == 2'b11) begin
         grant_o = (prio_i || (last_i == OWN_I)) ? OWN_D : OWN_I;
      end else if (req_i[1]) begin
         grant_o = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory, with a dummy
// read after each write so a later read cannot hit on stale latched data.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned       D_PRIORITY = 0,
   parameter logic [ADDR_W-1:0] INVAL_XOR  = INVAL_XOR_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_read_valid,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_enable,
   output logic [STRB_W-1:0] mem_write_wstrb,
   input  logic              mem_write_ready
);

   localparam logic PRIO = (D_PRIORITY != 32'd0);

   state_e            state_q, state_d;
   txn_t              txn_q, txn_d;
   owner_e            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] last_rd_addr_q, last_rd_addr_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic              i_gnt_q, i_gnt_d;
   logic              d_gnt_q, d_gnt_d;

   logic              pick_valid;
   owner_e            pick_owner;
   logic              rd_fire;
   logic              wr_fire;

   mem_arb_rr u_rr (
      .req_i   ({d_req, i_req}),
      .last_i  (last_grant_q),
      .prio_i  (PRIO),
      .valid_o (pick_valid),
      .grant_o (pick_owner)
   );

   assign rd_fire = (state_q == RD) && mem_read_valid;
   assign wr_fire = (state_q == WR) && mem_write_ready;

   // Memory strobes follow the state; write enable drops as soon as ready returns
   assign mem_address      = mem_address_q;
   assign mem_read_enable  = (state_q == RD) || (state_q == INVAL);
   assign mem_write_enable = (state_q == WR) && txn_q.we && !mem_write_ready;
   assign mem_write_data   = txn_q.wdata;
   assign mem_write_wstrb  = txn_q.wstrb;

   // Completion and read data are returned in the same cycle memory responds
   assign i_gnt   = i_gnt_q;
   assign d_gnt   = d_gnt_q;
   assign i_done  = rd_fire && (txn_q.owner == OWN_I);
   assign d_done  = (rd_fire && (txn_q.owner == OWN_D)) || wr_fire;
   assign i_rdata = (rd_fire && (txn_q.owner == OWN_I)) ? mem_read_data : '0;
   assign d_rdata = (rd_fire && (txn_q.owner == OWN_D)) ? mem_read_data : '0;

   // State and captured-transaction registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         txn_q          <= '0;
         last_grant_q   <= OWN_D;
         last_rd_addr_q <= '0;
         mem_address_q  <= '0;
         i_gnt_q        <= 1'b0;
         d_gnt_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         txn_q          <= txn_d;
         last_grant_q   <= last_grant_d;
         last_rd_addr_q <= last_rd_addr_d;
         mem_address_q  <= mem_address_d;
         i_gnt_q        <= i_gnt_d;
         d_gnt_q        <= d_gnt_d;
      end
   end

   // Next-state logic: grant, hold until memory completes, then invalidate after writes
   always_comb begin
      state_d        = state_q;
      txn_d          = txn_q;
      last_grant_d   = last_grant_q;
      last_rd_addr_d = last_rd_addr_q;
      mem_address_d  = mem_address_q;
      i_gnt_d        = 1'b0;
      d_gnt_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               last_grant_d = pick_owner;
               if (pick_owner == OWN_D) begin
                  txn_d.owner   = OWN_D;
                  txn_d.we      = d_we;
                  txn_d.addr    = d_addr;
                  txn_d.wdata   = d_wdata;
                  txn_d.wstrb   = d_wstrb;
                  mem_address_d = d_addr;
                  d_gnt_d       = 1'b1;
                  state_d       = d_we ? WR : RD;
               end else begin
                  txn_d.owner   = OWN_I;
                  txn_d.we      = 1'b0;
                  txn_d.addr    = i_addr;
                  txn_d.wdata   = '0;
                  txn_d.wstrb   = '0;
                  mem_address_d = i_addr;
                  i_gnt_d       = 1'b1;
                  state_d       = RD;
               end
            end
         end
         RD: begin
            if (mem_read_valid) begin
               last_rd_addr_d = txn_q.addr;
               state_d        = IDLE;
            end
         end
         WR: begin
            if (mem_write_ready) begin
               mem_address_d = last_rd_addr_q ^ INVAL_XOR;
               state_d       = INVAL;
            end
         end
         INVAL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latching single-port memory model.
module tb_mem_arbiter;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic [31:0] exp_inval;
   } vec_t;

   localparam logic [31:0] UART0 = 32'h1000_0000;

   logic        clk, reset, model_clr;
   logic        i_req, i_gnt, i_done;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_done;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic [31:0] mem_address, mem_read_data, mem_write_data;
   logic        mem_read_enable, mem_read_valid, mem_write_enable, mem_write_ready;
   logic [3:0]  mem_write_wstrb;

   logic        p_i_req, p_i_gnt, p_i_done;
   logic [31:0] p_i_addr, p_i_rdata;
   logic        p_d_req, p_d_we, p_d_gnt, p_d_done;
   logic [31:0] p_d_addr, p_d_wdata, p_d_rdata;
   logic [3:0]  p_d_wstrb;
   logic [31:0] p_mem_address, p_mem_read_data, p_mem_write_data;
   logic        p_mem_read_enable, p_mem_read_valid, p_mem_write_enable, p_mem_write_ready;
   logic [3:0]  p_mem_write_wstrb;

   int checks, errors;
   vec_t vecs [12];

   mem_arbiter #(.D_PRIORITY(0), .INVAL_XOR(32'h4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
      .mem_address(mem_address), .mem_read_enable(mem_read_enable),
      .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
      .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
      .mem_write_wstrb(mem_write_wstrb), .mem_write_ready(mem_write_ready)
   );

   mem_arbiter #(.D_PRIORITY(1), .INVAL_XOR(32'h4)) dut_pri (
      .clk(clk), .reset(reset),
      .i_req(p_i_req), .i_addr(p_i_addr), .i_gnt(p_i_gnt), .i_done(p_i_done), .i_rdata(p_i_rdata),
      .d_req(p_d_req), .d_we(p_d_we), .d_addr(p_d_addr), .d_wdata(p_d_wdata), .d_wstrb(p_d_wstrb),
      .d_gnt(p_d_gnt), .d_done(p_d_done), .d_rdata(p_d_rdata),
      .mem_address(p_mem_address), .mem_read_enable(p_mem_read_enable),
      .mem_read_data(p_mem_read_data), .mem_read_valid(p_mem_read_valid),
      .mem_write_data(p_mem_write_data), .mem_write_enable(p_mem_write_enable),
      .mem_write_wstrb(p_mem_write_wstrb), .mem_write_ready(p_mem_write_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: data latched on a read edge, valid while address matches the latch
   logic [31:0] mem [256];
   logic [31:0] lat_addr, lat_data;
   logic        lat_v, wr_ready_q;
   int          we_cycles, uart_cnt;
   logic [7:0]  uart_char;

   always @(posedge clk) begin
      if (model_clr) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
         lat_addr <= '0; lat_data <= '0; lat_v <= 1'b0; wr_ready_q <= 1'b0;
         we_cycles <= 0; uart_cnt <= 0; uart_char <= '0;
      end else begin
         wr_ready_q <= mem_write_enable;
         if (mem_write_enable) begin
            we_cycles <= we_cycles + 1;
            if (mem_address == UART0) begin
               uart_cnt  <= uart_cnt + 1;
               uart_char <= mem_write_data[7:0];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (mem_write_wstrb[b]) mem[mem_address[9:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
            end
         end
         if (mem_read_enable) begin
            lat_addr <= mem_address;
            lat_data <= mem[mem_address[9:2]];
            lat_v    <= 1'b1;
         end
      end
   end

   assign mem_read_data   = lat_data;
   assign mem_read_valid  = lat_v && (lat_addr == mem_address);
   assign mem_write_ready = wr_ready_q;

   // Trivial always-hit memory for the priority instance
   logic p_wr_ready_q;
   always @(posedge clk) p_wr_ready_q <= model_clr ? 1'b0 : p_mem_write_enable;
   assign p_mem_read_valid  = p_mem_read_enable;
   assign p_mem_read_data   = 32'h1234_5678;
   assign p_mem_write_ready = p_wr_ready_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transaction from an idle arbiter; latency counts the request cycle as 1
   task automatic run_txn(input vec_t v, input string tag);
      logic [31:0] rd;
      int lat, own_g, oth_g, we0;
      bit got;
      we0 = we_cycles;
      @(posedge clk); #1;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      lat = 0; got = 1'b0; own_g = 0; oth_g = 0; rd = '0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (v.is_d ? d_gnt : i_gnt) own_g++;
         if (v.is_d ? i_gnt : d_gnt) oth_g++;
         if (own_g > 0) begin
            d_addr = ~v.addr; d_wdata = ~v.wdata; i_addr = ~v.addr;
         end
         if (v.is_d ? d_done : i_done) begin
            got = 1'b1;
            rd  = v.is_d ? d_rdata : i_rdata;
            i_req = 1'b0; d_req = 1'b0;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, "_own_gnt"}, 32'(own_g), 32'd1);
      chk({tag, "_other_gnt"}, 32'(oth_g), 32'd0);
      if (!v.we) chk({tag, "_rdata"}, rd, v.exp_rdata);
      if (v.we) begin
         @(negedge clk);
         chk({tag, "_inval_ren"}, 32'(mem_read_enable), 32'd1);
         chk({tag, "_inval_addr"}, mem_address, v.exp_inval);
         chk({tag, "_inval_nodone"}, 32'({i_done, d_done}), 32'd0);
         chk({tag, "_we_cycles"}, 32'(we_cycles - we0), 32'd1);
      end
   endtask

   initial begin
      int order [8];
      int n, pi, pd, stray;
      bit seen;
      vec_t rv;
      checks = 0; errors = 0;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      p_i_req = 0; p_i_addr = '0; p_d_req = 0; p_d_we = 0; p_d_addr = '0; p_d_wdata = '0; p_d_wstrb = '0;
      reset = 1'b1; model_clr = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", 32'(mem_read_enable), 32'd0);
      chk("rst_wr_en", 32'(mem_write_enable), 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_gnt_done", 32'({i_gnt, d_gnt, i_done, d_done}), 32'd0);
      chk("rst_wstrb", 32'(mem_write_wstrb), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; model_clr = 1'b0;

      //         is_d we  addr           wdata          wstrb  exp_rdata      lat exp_inval
      vecs[0]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hC0DE_0000, 3, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hC0DE_0000, 2, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 32'hC0DE_0040, 3, 32'h0};
      vecs[3]  = '{1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0,         3, 32'h8000_0104};
      vecs[4]  = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 3, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h8000_0100, 32'h0000_00AA, 4'h1, 32'h0,         3, 32'h8000_0104};
      vecs[6]  = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 32'hDEAD_BEAA, 3, 32'h0};
      vecs[7]  = '{1'b1, 1'b1, 32'h8000_0100, 32'h0000_1234, 4'h3, 32'h0,         3, 32'h8000_0104};
      vecs[8]  = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         4'h0, 32'hDEAD_1234, 3, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'hC0DE_0002, 3, 32'h0};
      vecs[10] = '{1'b1, 1'b1, UART0,         32'h0000_0041, 4'h1, 32'h0,         3, 32'h8000_000C};
      vecs[11] = '{1'b0, 1'b0, 32'h8000_000C, 32'h0,         4'h0, 32'hC0DE_0003, 2, 32'h0};

      for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("v%0d", i));
      chk("uart_count", 32'(uart_cnt), 32'd1);
      chk("uart_char", 32'(uart_char), 32'h41);

      // Simultaneous requests after reset: fetch first, then strict alternation
      @(posedge clk); #1; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h8000_0000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0100;
      n = 0;
      for (int i = 0; i < 8; i++) order[i] = -1;
      repeat (14) begin
         @(negedge clk);
         if (i_gnt && n < 8) begin order[n] = 0; n++; end
         if (d_gnt && n < 8) begin order[n] = 1; n++; end
         if (i_done) chk("rr_i_rdata", i_rdata, 32'hC0DE_0000);
         if (d_done) chk("rr_d_rdata", d_rdata, 32'hDEAD_1234);
      end
      @(posedge clk); #1; i_req = 1'b0; d_req = 1'b0;
      repeat (8) @(posedge clk);
      chk("rr_grants_ge4", 32'(n >= 4), 32'd1);
      chk("rr_order0", 32'(order[0]), 32'd0);
      chk("rr_order1", 32'(order[1]), 32'd1);
      chk("rr_order2", 32'(order[2]), 32'd0);
      chk("rr_order3", 32'(order[3]), 32'd1);

      // Reset during a read miss, then confirm nothing leaks out afterwards
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h8000_0010;
      @(negedge clk);
      @(negedge clk);
      chk("midrd_ren", 32'(mem_read_enable), 32'd1);
      chk("midrd_no_done", 32'(i_done), 32'd0);
      reset = 1'b1; i_req = 1'b0;
      @(negedge clk);
      chk("midrd_rst_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
      chk("midrd_rst_addr", mem_address, 32'd0);
      chk("midrd_rst_gnt_done", 32'({i_gnt, d_gnt, i_done, d_done}), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (i_done || d_done || i_gnt || d_gnt || mem_read_enable) stray++;
      end
      chk("midrd_no_stray", 32'(stray), 32'd0);
      rv = '{1'b1, 1'b1, 32'h8000_0020, 32'h0000_0055, 4'hF, 32'h0, 3, 32'h0000_0004};
      run_txn(rv, "post_rst_wr");

      // Fixed data priority: fetch starves while data keeps requesting
      @(posedge clk); #1;
      p_i_req = 1'b1; p_i_addr = 32'h8000_0000;
      p_d_req = 1'b1; p_d_we = 1'b0; p_d_addr = 32'h8000_0200;
      pi = 0; pd = 0;
      repeat (30) begin
         @(negedge clk);
         if (p_i_gnt) pi++;
         if (p_d_gnt) pd++;
      end
      chk("pri_i_starved", 32'(pi), 32'd0);
      chk("pri_d_gnt_ge10", 32'(pd >= 10), 32'd1);
      @(posedge clk); #1; p_d_req = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (p_i_gnt) seen = 1'b1;
      end
      chk("pri_i_after_drop", 32'(seen), 32'd1);
      @(posedge clk); #1; p_i_req = 1'b0;
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
